// File: rtl/hamming_frame_rx_pkg.sv
// hamming_frame_rx_pkg: shared Hamming(12,8) definitions for the frame receiver and transmit-side encoder
package hamming_frame_rx_pkg;

    localparam int CODE_W = 12;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // code position (1-based) carrying each payload bit data[i]
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

    // even parity at positions 1,2,4,8 over every position sharing that bit
    function automatic logic [CODE_W-1:0] hamming12_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic p;
        c = '0;
        for (int i = 0; i < DATA_W; i++) c[DATA_POS[i]-1] = d[i];
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int j = 1; j <= CODE_W; j++) if (j[k]) p = p ^ c[j-1];
            c[(1 << k)-1] = p;
        end
        return c;
    endfunction

endpackage

// File: rtl/hamming12_correct.sv
// hamming12_correct: syndrome, single-bit correction and payload extraction for one codeword
module hamming12_correct
    import hamming_frame_rx_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data,
    output logic              corrected,
    output logic              uncorrectable
);

    logic [3:0]        syn;
    logic [CODE_W-1:0] fixed;

    // syndrome is the XOR of the positions of all set bits; flip that position when it exists
    always_comb begin
        syn = '0;
        for (int p = 1; p <= CODE_W; p++) syn = syn ^ (code[p-1] ? 4'(p) : 4'd0);
        fixed = code;
        for (int p = 1; p <= CODE_W; p++) fixed[p-1] = code[p-1] ^ (syn == 4'(p));
        for (int i = 0; i < DATA_W; i++) data[i] = fixed[DATA_POS[i]-1];
        corrected     = (syn != 4'd0) && (syn <= 4'(CODE_W));
        uncorrectable = syn > 4'(CODE_W);
    end

endmodule

// File: rtl/hamming_frame_rx.sv
// hamming_frame_rx: oversampling serial receiver for Hamming(12,8) framed bytes
module hamming_frame_rx
    import hamming_frame_rx_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              corrected,
    output logic              uncorrectable,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   line;
    logic                   line_d;
    state_t                 state;
    logic [CW-1:0]          phase;
    logic [3:0]             bit_cnt;
    logic [CODE_W-1:0]      shreg;
    logic [DATA_W-1:0]      dec_data;
    logic                   dec_corr;
    logic                   dec_unc;

    assign line = sync[SYNC_STAGES-1];
    assign busy = state != IDLE;

    hamming12_correct u_correct (
        .code         (shreg),
        .data         (dec_data),
        .corrected    (dec_corr),
        .uncorrectable(dec_unc)
    );

    // synchronize the asynchronous line and keep one delayed copy for start-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync   <= '1;
            line_d <= 1'b1;
        end else begin
            sync[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            line_d <= line;
        end
    end

    // frame FSM: start validation, mid-bit sampling, stop check and registered decode outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            phase         <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            corrected     <= 1'b0;
            uncorrectable <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (line_d && !line) begin
                        state <= START;
                        phase <= '0;
                    end
                end
                START: begin
                    if (phase == HALF) begin
                        phase   <= '0;
                        bit_cnt <= '0;
                        state   <= line ? IDLE : DATA;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                DATA: begin
                    if (phase == LAST) begin
                        phase <= '0;
                        shreg <= {shreg[CODE_W-2:0], line};
                        if (bit_cnt == 4'(CODE_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                STOP: begin
                    if (phase == LAST) begin
                        phase <= '0;
                        state <= IDLE;
                        if (line) begin
                            data          <= dec_data;
                            corrected     <= dec_corr;
                            uncorrectable <= dec_unc;
                            data_valid    <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
